outline_segment_sequencer: RTL

//  Rasterises a closed polygon outline (ship or projectile) for one queried pixel.

---
 rtl/spacewar_pkg.sv | 22 ++
 rtl/outline_vertex_mux.sv | 44 ++++
 rtl/outline_segment_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/spacewar_pkg.sv
// -----------------------------------------------------------------------------
// spacewar_pkg
// Definitions shared by the outline rasteriser blocks:
//   COORD_W    default screen coordinate width, bits
//   state_t    sequencer state encoding, with the ST_* constants
//   idx_width  width of an index that counts 0..n-1 (minimum 1 bit)
// -----------------------------------------------------------------------------
package spacewar_pkg;

    localparam int COORD_W = 5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SCAN = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/outline_vertex_mux.sv
// -----------------------------------------------------------------------------
// outline_vertex_mux
// Combinational edge selector. For edge index idx it returns the start vertex
// v[idx] and the end vertex v[idx+1]. The last edge closes the outline back to
// v[0].
// Ports:
//   in_verts_x/y  packed vertex lists, vertex i at [i*WIDTH +: WIDTH]
//   in_idx        edge index, 0..N_VERTS-1
//   out_ax/ay     edge start vertex
//   out_cx/cy     edge end vertex
// -----------------------------------------------------------------------------
module outline_vertex_mux #(
    parameter int WIDTH   = 5,
    parameter int N_VERTS = 4,
    parameter int IDX_W   = 2
) (
    input  logic [N_VERTS*WIDTH-1:0] in_verts_x,
    input  logic [N_VERTS*WIDTH-1:0] in_verts_y,
    input  logic [IDX_W-1:0]         in_idx,
    output logic [WIDTH-1:0]         out_ax,
    output logic [WIDTH-1:0]         out_ay,
    output logic [WIDTH-1:0]         out_cx,
    output logic [WIDTH-1:0]         out_cy
);

    // A compare-and-select loop, rather than a computed part-select, keeps the
    // wrap explicit and never addresses past the end of the list when
    // N_VERTS is not a power of two.
    always_comb begin
        out_ax = '0;
        out_ay = '0;
        out_cx = '0;
        out_cy = '0;
        for (int i = 0; i < N_VERTS; i++) begin
            if (in_idx == IDX_W'(i)) begin
                out_ax = in_verts_x[i*WIDTH +: WIDTH];
                out_ay = in_verts_y[i*WIDTH +: WIDTH];
                out_cx = in_verts_x[((i + 1) % N_VERTS)*WIDTH +: WIDTH];
                out_cy = in_verts_y[((i + 1) % N_VERTS)*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/outline_segment_sequencer.sv
// -----------------------------------------------------------------------------
// outline_segment_sequencer
// Walks every edge of a closed polygon outline for one queried pixel. Each edge
// is presented, together with the pixel, to the downstream combinational
// on-line detector. The detector hits are ORed into one per-pixel result.
//
//   state | meaning
//   IDLE  | waiting for in_start, last result held on out_pixel
//   SCAN  | one edge per cycle, in_hit accumulated
//   DONE  | one cycle, out_done=1, out_pixel valid; in_start accepted
//
// Ports:
//   in_clk, in_reset     clock, synchronous active-high reset
//   in_start             scan request, ignored while out_busy=1
//   in_px/in_py          queried pixel
//   in_verts_x/y         packed vertex lists, vertex i at [i*WIDTH +: WIDTH]
//   in_hit               detector result for the edge currently driven
//   out_ax/ay, out_cx/cy current edge start/end vertex (to detector)
//   out_bx/by            latched pixel (to detector)
//   out_segment          constant 1, segment-bounded test
//   out_busy             high in SCAN
//   out_done             one-cycle pulse, result valid
//   out_pixel            OR of hits, held until the next result
//
// Build option SEG_EARLY_EXIT_EN: when defined, the first hit ends the scan,
// so latency varies from 1 to N_VERTS scan cycles. When undefined every edge
// is always scanned, which gives a fixed latency.
// -----------------------------------------------------------------------------
module outline_segment_sequencer
    import spacewar_pkg::*;
#(
    parameter int WIDTH   = COORD_W,
    parameter int N_VERTS = 4
) (
    input  logic                     in_clk,
    input  logic                     in_reset,
    input  logic                     in_start,
    input  logic [WIDTH-1:0]         in_px,
    input  logic [WIDTH-1:0]         in_py,
    input  logic [N_VERTS*WIDTH-1:0] in_verts_x,
    input  logic [N_VERTS*WIDTH-1:0] in_verts_y,
    input  logic                     in_hit,
    output logic [WIDTH-1:0]         out_ax,
    output logic [WIDTH-1:0]         out_ay,
    output logic [WIDTH-1:0]         out_cx,
    output logic [WIDTH-1:0]         out_cy,
    output logic [WIDTH-1:0]         out_bx,
    output logic [WIDTH-1:0]         out_by,
    output logic                     out_segment,
    output logic                     out_busy,
    output logic                     out_done,
    output logic                     out_pixel
);

    localparam int               IDX_W    = idx_width(N_VERTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VERTS - 1);

    state_t                   r_state;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_acc;
    logic                     r_pixel;
    logic [WIDTH-1:0]         r_px;
    logic [WIDTH-1:0]         r_py;
    logic [N_VERTS*WIDTH-1:0] r_vx;
    logic [N_VERTS*WIDTH-1:0] r_vy;

    logic w_last;
    logic w_finish;

    assign w_last = (r_idx == LAST_IDX);

`ifdef SEG_EARLY_EXIT_EN
    assign w_finish = w_last || in_hit;
`else
    assign w_finish = w_last;
`endif

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_acc   <= 1'b0;
            r_pixel <= 1'b0;
            r_px    <= '0;
            r_py    <= '0;
            r_vx    <= '0;
            r_vy    <= '0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    r_acc <= r_acc | in_hit;
                    if (w_finish) begin
                        r_state <= ST_DONE;
                        r_pixel <= r_acc | in_hit;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a start, so back-to-back
                    // requests need no idle bubble.
                    r_state <= ST_IDLE;
                    if (in_start) begin
                        r_state <= ST_SCAN;
                        r_idx   <= '0;
                        r_acc   <= 1'b0;
                        r_px    <= in_px;
                        r_py    <= in_py;
                        r_vx    <= in_verts_x;
                        r_vy    <= in_verts_y;
                    end
                end
            endcase
        end
    end

    // The edge is decoded from the held index and snapshot, so the detector
    // ports keep their last values outside SCAN without extra registers.
    outline_vertex_mux #(
        .WIDTH   (WIDTH),
        .N_VERTS (N_VERTS),
        .IDX_W   (IDX_W)
    ) u_vertex_mux (
        .in_verts_x (r_vx),
        .in_verts_y (r_vy),
        .in_idx     (r_idx),
        .out_ax     (out_ax),
        .out_ay     (out_ay),
        .out_cx     (out_cx),
        .out_cy     (out_cy)
    );

    assign out_bx      = r_px;
    assign out_by      = r_py;
    assign out_segment = 1'b1;
    assign out_busy    = (r_state == ST_SCAN);
    assign out_done    = (r_state == ST_DONE);
    assign out_pixel   = r_pixel;

endmodule
